// File: rtl/lc3_pipe_ctrl.sv
// LC-3 pipeline controller: registered FSM for multi-cycle and indirect memory access, plus a branch flush window.
// Optional stall watchdog compiled in with `define LC3_CTRL_WATCHDOG_EN.
module lc3_pipe_ctrl #(
    parameter int BR_PENALTY     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        complete_instr,
    input  logic        complete_data,
    input  logic [15:0] IR_exec,
    input  logic [2:0]  psr,
    output logic        enable_updatePC,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        br_taken,
    output logic        flush,
    output logic [1:0]  mem_state,
    output logic        timeout
);

    typedef enum logic [1:0] {RUN, MEM_IND, MEM_ACC, FLUSH} state_t;

    localparam logic [1:0] MS_READ  = 2'b00;
    localparam logic [1:0] MS_IND   = 2'b01;
    localparam logic [1:0] MS_WRITE = 2'b10;
    localparam logic [1:0] MS_IDLE  = 2'b11;
    localparam logic [2:0] PENALTY  = 3'(BR_PENALTY);

    state_t      state, state_next;
    logic        acc_write;   // 1: pending MEM_ACC is a write (ST/STR/STI)
    logic [2:0]  flush_cnt;
    logic [4:0]  en;          // {updatePC, fetch, decode, execute, writeback}
    logic        wd_fire;

    logic [3:0] opcode;
    logic       is_ctrl, is_ldst, is_ind;

    assign opcode  = IR_exec[15:12];
    assign is_ctrl = ((opcode == 4'b0000) && |(psr & IR_exec[11:9]))
                   || (opcode == 4'b1100) || (opcode == 4'b0100) || (opcode == 4'b1111);
    assign is_ldst = (opcode == 4'b0010) || (opcode == 4'b0110)
                   || (opcode == 4'b0011) || (opcode == 4'b0111);
    assign is_ind  = (opcode == 4'b1010) || (opcode == 4'b1011);

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        state_next = state;
        en         = 5'b11111;
        br_taken   = 1'b0;
        flush      = 1'b0;
        mem_state  = MS_IDLE;
        case (state)
            RUN: begin
                if (is_ldst) begin
                    // Bit 12 separates stores (0011/0111) from loads (0010/0110).
                    mem_state = IR_exec[12] ? MS_WRITE : MS_READ;
                    if (complete_data)
                        en = complete_instr ? 5'b11111 : 5'b00011;
                    else begin
                        en         = 5'b00000;
                        state_next = MEM_ACC;
                    end
                end else if (is_ind) begin
                    mem_state  = MS_IND;
                    en         = 5'b00000;
                    state_next = MEM_IND;
                end else if (!complete_instr) begin
                    en = 5'b00000;
                end else if (is_ctrl) begin
                    br_taken = 1'b1;
                    if (BR_PENALTY > 0)
                        state_next = FLUSH;
                end
            end
            MEM_IND: begin
                mem_state = MS_IND;
                en        = 5'b00000;
                if (complete_data)
                    state_next = MEM_ACC;
            end
            MEM_ACC: begin
                mem_state = acc_write ? MS_WRITE : MS_READ;
                if (complete_data) begin
                    // Without a fetched instruction only the back end may retire the access.
                    en         = complete_instr ? 5'b11111 : 5'b00011;
                    state_next = RUN;
                end else begin
                    en = 5'b00000;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                en    = {complete_instr, complete_instr, 3'b000};
                if (complete_instr && (flush_cnt == 3'd1))
                    state_next = RUN;
            end
            default: state_next = RUN;
        endcase
        if (reset) begin
            en        = 5'b00000;
            br_taken  = 1'b0;
            flush     = 1'b0;
            mem_state = MS_IDLE;
        end
    end

    assign {enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback} = en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RUN;
            acc_write <= 1'b0;
            flush_cnt <= 3'd0;
        end else begin
            state <= wd_fire ? RUN : state_next;
            if (state == RUN)
                acc_write <= IR_exec[12];
            if ((state != FLUSH) && (state_next == FLUSH))
                flush_cnt <= PENALTY;
            else if ((state == FLUSH) && complete_instr)
                flush_cnt <= flush_cnt - 3'd1;
        end
    end

`ifdef LC3_CTRL_WATCHDOG_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    logic        awaited;
    logic [15:0] wd_cnt, wd_cnt_inc;
    logic        timeout_q;

    // The completion the FSM is currently waiting on.
    assign awaited    = ((state == MEM_IND) || (state == MEM_ACC)) ? complete_data : complete_instr;
    assign wd_cnt_inc = wd_cnt + 16'd1;
    assign wd_fire    = !awaited && (wd_cnt_inc == TIMEOUT_W);
    assign timeout    = timeout_q & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt    <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (awaited || wd_fire)
                wd_cnt <= 16'd0;
            else
                wd_cnt <= wd_cnt_inc;
            if (wd_fire)
                timeout_q <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
// Directed bench for lc3_pipe_ctrl (BR_PENALTY=2, TIMEOUT_CYCLES=4); watchdog cases need LC3_CTRL_WATCHDOG_EN.
module tb_lc3_pipe_ctrl;

    localparam logic [15:0] OP_ADD = 16'h1000;
    localparam logic [15:0] OP_LD  = 16'h2000;
    localparam logic [15:0] OP_ST  = 16'h3000;
    localparam logic [15:0] OP_STR = 16'h7000;
    localparam logic [15:0] OP_LDI = 16'hA000;
    localparam logic [15:0] OP_JMP = 16'hC1C0;
    localparam logic [15:0] OP_BRZ = 16'h0402;

    logic        clock, reset, complete_instr, complete_data;
    logic [15:0] IR_exec;
    logic [2:0]  psr;
    logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
    logic        br_taken, flush, timeout;
    logic [1:0]  mem_state;

    int n_pass  = 0;
    int n_total = 0;

    lc3_pipe_ctrl #(.BR_PENALTY(2), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .complete_instr(complete_instr), .complete_data(complete_data),
        .IR_exec(IR_exec), .psr(psr),
        .enable_updatePC(enable_updatePC), .enable_fetch(enable_fetch),
        .enable_decode(enable_decode), .enable_execute(enable_execute),
        .enable_writeback(enable_writeback),
        .br_taken(br_taken), .flush(flush), .mem_state(mem_state), .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Apply inputs shortly after a rising edge; outputs settle before sampling.
    task automatic drive(input logic ci, input logic cd, input logic [15:0] ir);
        complete_instr = ci;
        complete_data  = cd;
        IR_exec        = ir;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] en, input logic br,
                              input logic fl, input logic [1:0] ms);
        check({tag, "_en"}, 16'({enable_updatePC, enable_fetch, enable_decode,
                                 enable_execute, enable_writeback}), 16'(en));
        check({tag, "_br"}, 16'(br_taken), 16'(br));
        check({tag, "_fl"}, 16'(flush), 16'(fl));
        check({tag, "_ms"}, 16'(mem_state), 16'(ms));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        psr   = 3'b000;
        #1;
        // Reset held with LD in Execute: everything idle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, OP_LD);
            expect_out($sformatf("rst%0d", i), 5'b00000, 1'b0, 1'b0, 2'b11);
            check("rst_timeout", 16'(timeout), 16'h0);
            tick();
        end
        reset = 1'b0;

        // LD, data completes two cycles after detection.
        drive(1'b1, 1'b0, OP_LD);  expect_out("ld_t0", 5'b00000, 1'b0, 1'b0, 2'b00); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("ld_t1", 5'b00000, 1'b0, 1'b0, 2'b00); tick();
        drive(1'b1, 1'b1, OP_ADD); expect_out("ld_t2", 5'b11111, 1'b0, 1'b0, 2'b00); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("ld_t3", 5'b11111, 1'b0, 1'b0, 2'b11); tick();

        // BRz taken with Z set: br_taken, then two flush cycles.
        psr = 3'b010;
        drive(1'b1, 1'b0, OP_BRZ); expect_out("brz_t0", 5'b11111, 1'b1, 1'b0, 2'b11); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("brz_t1", 5'b11000, 1'b0, 1'b1, 2'b11); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("brz_t2", 5'b11000, 1'b0, 1'b1, 2'b11); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("brz_t3", 5'b11111, 1'b0, 1'b0, 2'b11); tick();

        // BRz with only N set: ordinary instruction.
        psr = 3'b100;
        drive(1'b1, 1'b0, OP_BRZ); expect_out("brn_t0", 5'b11111, 1'b0, 1'b0, 2'b11); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("brn_t1", 5'b11111, 1'b0, 1'b0, 2'b11); tick();

        // LDI with complete_data pulsed at T+2 and T+5.
        drive(1'b1, 1'b0, OP_LDI); expect_out("ldi_t0", 5'b00000, 1'b0, 1'b0, 2'b01); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("ldi_t1", 5'b00000, 1'b0, 1'b0, 2'b01); tick();
        drive(1'b1, 1'b1, OP_ADD); expect_out("ldi_t2", 5'b00000, 1'b0, 1'b0, 2'b01); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("ldi_t3", 5'b00000, 1'b0, 1'b0, 2'b00); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("ldi_t4", 5'b00000, 1'b0, 1'b0, 2'b00); tick();
        drive(1'b1, 1'b1, OP_ADD); expect_out("ldi_t5", 5'b11111, 1'b0, 1'b0, 2'b00); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("ldi_t6", 5'b11111, 1'b0, 1'b0, 2'b11); tick();

        // JMP waiting on the fetch, then a flush window that stalls for one cycle.
        drive(1'b0, 1'b0, OP_JMP); expect_out("jmp_t0", 5'b00000, 1'b0, 1'b0, 2'b11); tick();
        drive(1'b0, 1'b0, OP_JMP); expect_out("jmp_t1", 5'b00000, 1'b0, 1'b0, 2'b11); tick();
        drive(1'b1, 1'b0, OP_JMP); expect_out("jmp_t2", 5'b11111, 1'b1, 1'b0, 2'b11); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("jmp_t3", 5'b11000, 1'b0, 1'b1, 2'b11); tick();
        drive(1'b0, 1'b0, OP_ADD); expect_out("jmp_t4", 5'b00000, 1'b0, 1'b1, 2'b11); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("jmp_t5", 5'b11000, 1'b0, 1'b1, 2'b11); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("jmp_t6", 5'b11111, 1'b0, 1'b0, 2'b11); tick();

        // STR completing in its detection cycle stays in RUN.
        drive(1'b1, 1'b1, OP_STR); expect_out("str_t0", 5'b11111, 1'b0, 1'b0, 2'b10); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("str_t1", 5'b11111, 1'b0, 1'b0, 2'b11); tick();

        // ST completing while the fetch is still outstanding: back end only.
        drive(1'b1, 1'b0, OP_ST);  expect_out("st_t0", 5'b00000, 1'b0, 1'b0, 2'b10); tick();
        drive(1'b0, 1'b1, OP_ADD); expect_out("st_t1", 5'b00011, 1'b0, 1'b0, 2'b10); tick();
        drive(1'b1, 1'b0, OP_ADD); expect_out("st_t2", 5'b11111, 1'b0, 1'b0, 2'b11); tick();

        // Reset in the middle of an LD abandons the access.
        drive(1'b1, 1'b0, OP_LD);  expect_out("rld_t0", 5'b00000, 1'b0, 1'b0, 2'b00); tick();
        reset = 1'b1;
        drive(1'b1, 1'b0, OP_ADD); expect_out("rld_rst", 5'b00000, 1'b0, 1'b0, 2'b11); tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, OP_ADD); expect_out("rld_t2", 5'b11111, 1'b0, 1'b0, 2'b11); tick();

`ifdef LC3_CTRL_WATCHDOG_EN
        // LD with data stuck low: four stalled cycles, then timeout and a forced return to RUN.
        drive(1'b1, 1'b0, OP_LD);  expect_out("wd_t0", 5'b00000, 1'b0, 1'b0, 2'b00); tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, OP_ADD);
            check($sformatf("wd_t%0d_ms", i), 16'(mem_state), 16'h0);
            check($sformatf("wd_t%0d_to", i), 16'(timeout), 16'h0);
            tick();
        end
        drive(1'b1, 1'b0, OP_ADD);
        check("wd_t5_ms", 16'(mem_state), 16'h3);
        check("wd_t5_to", 16'(timeout), 16'h1);
        tick();
        drive(1'b1, 1'b0, OP_ADD);
        check("wd_t6_to", 16'(timeout), 16'h1);
        tick();
        reset = 1'b1;
        drive(1'b1, 1'b0, OP_ADD);
        check("wd_rst_to", 16'(timeout), 16'h0);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, OP_ADD);
        check("wd_after_to", 16'(timeout), 16'h0);
        tick();
`else
        // Without the watchdog an indefinite data stall never raises timeout.
        drive(1'b1, 1'b0, OP_LD); tick();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, OP_ADD);
            check($sformatf("nowd%0d_ms", i), 16'(mem_state), 16'h0);
            check($sformatf("nowd%0d_to", i), 16'(timeout), 16'h0);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lc3_pipe_ctrl.md
# lc3_pipe_ctrl

Parametrised successor to the LC-3 pipeline controller, sitting between Fetch/Decode/Execute/Writeback and the instruction/data memory handshakes. It adds what the combinational controller lacks. A registered FSM sequences multi-cycle memory accesses, including the two-phase LDI/STI indirect access. A configurable flush window follows every taken control transfer. An optional stall watchdog can be compiled in. All outputs are Mealy functions of registered state plus current inputs.

## Interface
- BR_PENALTY, 2: bubble cycles after a taken control transfer; legal range 0..7; 0 removes the FLUSH state.
- TIMEOUT_CYCLES, 255: consecutive stalled cycles before the watchdog fires; legal range 1..65535; used only with the watchdog macro.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- complete_instr  in  1  instruction memory has returned the fetch.
- complete_data  in  1  data memory has completed the current access.
- IR_exec  in  16  instruction in the Execute stage.
- psr  in  3  NZP flags.
- enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback  out  1 each  stage enables.
- br_taken  out  1  one-cycle select for the PC target mux.
- flush  out  1  Decode/Execute contents are bubbles.
- mem_state  out  2  00 read, 01 indirect-address read, 10 write, 11 idle.
- timeout  out  1  sticky watchdog flag; tied 0 without the macro.

## Operation
- States: RUN, MEM_IND, MEM_ACC, FLUSH.
- Opcode classes, from IR_exec[15:12]:
  - ctrl: BR 0000 when |(psr & IR_exec[11:9]), plus JMP 1100, JSR 0100, TRAP 1111.
  - load: LD 0010, LDR 0110.
  - store: ST 0011, STR 0111.
  - indirect: LDI 1010, STI 1011.
- RUN outputs:
  - Default: all enables 1, br_taken 0, flush 0, mem_state 11.
  - complete_instr=0: all enables 0 and state held. This overrides ctrl detection; br_taken stays 0 until complete_instr=1.
  - ctrl and complete_instr=1: br_taken=1 and all enables 1. Next state is FLUSH if BR_PENALTY>0, else RUN. BR with no matching flag is ordinary.
  - load/store: mem_state 00/10, enables 0. If complete_data=1 in the same cycle, this is the completion cycle: enables 1, stay in RUN. Otherwise go to MEM_ACC.
  - indirect: mem_state 01, enables 0, go to MEM_IND.
- MEM_IND: mem_state 01, enables 0. On complete_data=1, go to MEM_ACC; mem_state there is 00 for LDI, 10 for STI.
- MEM_ACC:
  - mem_state is the access type; enables 0.
  - On complete_data=1 and complete_instr=1: all five enables 1, go to RUN.
  - On complete_data=1 and complete_instr=0: enable_execute and enable_writeback 1, fetch/decode/updatePC 0, go to RUN.
- FLUSH:
  - Down-counter loaded with BR_PENALTY on entry.
  - Outputs: flush=1, enable_fetch=enable_updatePC=complete_instr, decode/execute/writeback 0.
  - Counter decrements only when complete_instr=1; return to RUN when it reaches 1 and decrements.
- Memory-op detection ignores complete_instr.
- While reset=1, every output is at its reset value: all enables 0, br_taken 0, flush 0, mem_state 11, timeout 0. The state register loads RUN and counters clear on the reset edge. A reset mid-access or mid-flush abandons it.

## Timing
- Ctrl detected in cycle T: br_taken in T, flush in T+1..T+BR_PENALTY (no instruction stall), RUN in T+BR_PENALTY+1.
- LD with data completing k cycles after detection (k≥1): mem_state 00 in T..T+k, enables 1 in T+k, new IR in RUN at T+k+1.
- LDI: mem_state 01 from T until the first complete_data, then 00 until the second. Minimum 3 cycles when complete_data is held high.
- complete_data is ignored outside MEM_IND/MEM_ACC and the RUN detection cycle.
- Combinational paths: inputs to outputs, with no combinational loop.

## Configuration
- LC3_CTRL_WATCHDOG_EN defined:
  - A 16-bit counter increments every cycle in which an awaited completion is low. That means complete_instr in RUN/FLUSH, complete_data in MEM_IND/MEM_ACC.
  - The counter clears on any completion.
  - When it reaches TIMEOUT_CYCLES, timeout sets (sticky until reset), the FSM forces RUN with mem_state 11, and the counter clears.
- LC3_CTRL_WATCHDOG_EN undefined: no counter, timeout is constant 0, and stalls wait indefinitely.

## Test plan
- Reset held 3 cycles with LD in IR_exec: all enables 0 and mem_state 11 throughout; LD detected on the first post-reset cycle.
- BRz (0x0402), psr=010, BR_PENALTY=2: br_taken in T, flush in T+1 and T+2, enables all 1 in T+3. With psr=100: no br_taken, no flush.
- LDI (0xA000), complete_data pulsed at T+2 and T+5: mem_state 01 in T..T+2, 00 in T+3..T+5, all enables 1 only at T+5.
- JMP (0xC1C0) with complete_instr=0 in T and T+1: br_taken 0 in T and T+1, 1 in T+2, then flush.
- STR with complete_data=1 in the detection cycle: mem_state 10, enables 1 same cycle, state stays RUN.
- Watchdog enabled, TIMEOUT_CYCLES=4, LD with complete_data stuck low: timeout rises after 4 stalled cycles, mem_state returns to 11, and timeout stays 1 until reset.
